// File: rtl/cbc_ctl_in.sv
// cbc_ctl_in: input-side controller of the AES CBC datapath.
// Pops framed words from an FWFT FIFO, packs four of them into a 128-bit
// block, XORs with the IV or the previous ciphertext and launches the AES core.
// Build option: define CBC_CHAIN_EN for CBC chaining; without it the block
// goes to the core unchained (ECB) and i_iv / i_chain are ignored.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for a 01-flagged word to open a message
// FILL  | collecting words into the current block (lane idx)
// START | one-cycle start pulse, block already registered on o_aes_data
// WAIT  | core busy; no pops until i_aes_done
module cbc_ctl_in #(
   parameter int MAX_WORDS = 252
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_empty_fifo,
   input  logic [33:0]  i_data_in,
   output logic         o_rd_in,
   input  logic [127:0] i_iv,
   input  logic [127:0] i_chain,
   input  logic         i_aes_done,
   output logic         o_aes_start,
   output logic [127:0] o_aes_data,
   output logic [7:0]   o_data_len,
   output logic         o_busy,
   output logic         o_err
);

   typedef enum logic [1:0] {IDLE, FILL, START, WAIT} state_t;

   localparam logic [1:0] FLAG_FIRST = 2'b01;
   localparam logic [1:0] FLAG_LAST  = 2'b10;
   localparam logic [1:0] FLAG_RSVD  = 2'b11;
   localparam logic [7:0] MAX_CNT    = 8'(MAX_WORDS);

   state_t       state_q, state_d;
   logic [1:0]   idx_q, idx_d;
   logic [95:0]  blk_q, blk_d;
   logic [7:0]   cnt_q, cnt_d;
   logic         last_q, last_d;
   logic [7:0]   len_q, len_d;
   logic [127:0] data_q, data_d;
   logic         err_q, err_d;
`ifdef CBC_CHAIN_EN
   logic [127:0] chain_q, chain_d;
`else
   logic         unused_chain_inputs;
   assign unused_chain_inputs = ^{i_iv, i_chain};
`endif

   logic [1:0]   flag;
   logic [31:0]  payload;
   logic         pop;
   logic [127:0] blk_full;

   assign flag    = i_data_in[33:32];
   assign payload = i_data_in[31:0];

   // Pops only while collecting words; held off during reset so nothing is consumed.
   assign pop = rst_n && !i_empty_fifo && (state_q == IDLE || state_q == FILL);

   assign o_rd_in     = pop;
   assign o_aes_start = (state_q == START);
   assign o_busy      = (state_q != IDLE);
   assign o_aes_data  = data_q;
   assign o_data_len  = len_q;
   assign o_err       = err_q;

   // Next-state, block packing, word counting and framing checks.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      blk_d    = blk_q;
      cnt_d    = cnt_q;
      last_d   = last_q;
      len_d    = len_q;
      data_d   = data_q;
      err_d    = 1'b0;
`ifdef CBC_CHAIN_EN
      chain_d  = chain_q;
`endif
      blk_full = '0;

      case (state_q)
         IDLE: begin
            if (pop) begin
               if (flag == FLAG_FIRST) begin
                  blk_d   = {64'h0, payload};
`ifdef CBC_CHAIN_EN
                  chain_d = i_iv;
`endif
                  cnt_d   = 8'd1;
                  idx_d   = 2'd1;
                  last_d  = 1'b0;
                  len_d   = 8'd0;
                  state_d = FILL;
               end else begin
                  err_d = 1'b1;
               end
            end
         end

         FILL: begin
            if (pop) begin
               if (flag == FLAG_FIRST) begin
                  // A new message header mid-block: drop the partial message.
                  blk_d   = {64'h0, payload};
`ifdef CBC_CHAIN_EN
                  chain_d = i_iv;
`endif
                  cnt_d   = 8'd1;
                  idx_d   = 2'd1;
                  last_d  = 1'b0;
                  len_d   = 8'd0;
                  err_d   = 1'b1;
               end else begin
                  if (flag == FLAG_RSVD) begin
                     err_d = 1'b1;
                  end
                  if (cnt_q >= MAX_CNT) begin
                     err_d = 1'b1;
                  end else begin
                     cnt_d = cnt_q + 8'd1;
                  end
                  if (flag == FLAG_LAST) begin
                     last_d = 1'b1;
                     len_d  = (cnt_d + 8'd3) & 8'hFC;
                  end
                  // Lanes above the current word are zero, which pads short blocks.
                  case (idx_q)
                     2'd0:    blk_full = {96'h0, payload};
                     2'd1:    blk_full = {64'h0, payload, blk_q[31:0]};
                     2'd2:    blk_full = {32'h0, payload, blk_q[63:0]};
                     default: blk_full = {payload, blk_q[95:0]};
                  endcase
                  if (idx_q == 2'd3 || flag == FLAG_LAST) begin
                     if (idx_q != 2'd3) begin
                        err_d = 1'b1;
                     end
`ifdef CBC_CHAIN_EN
                     data_d = blk_full ^ chain_q;
`else
                     data_d = blk_full;
`endif
                     state_d = START;
                  end else begin
                     blk_d = blk_full[95:0];
                     idx_d = idx_q + 2'd1;
                  end
               end
            end
         end

         START: begin
            state_d = WAIT;
         end

         WAIT: begin
            if (i_aes_done) begin
`ifdef CBC_CHAIN_EN
               chain_d = i_chain;
`endif
               idx_d   = 2'd0;
               state_d = last_q ? IDLE : FILL;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers, cleared asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= 2'd0;
         blk_q   <= '0;
         cnt_q   <= 8'd0;
         last_q  <= 1'b0;
         len_q   <= 8'd0;
         data_q  <= '0;
         err_q   <= 1'b0;
`ifdef CBC_CHAIN_EN
         chain_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         blk_q   <= blk_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
         len_q   <= len_d;
         data_q  <= data_d;
         err_q   <= err_d;
`ifdef CBC_CHAIN_EN
         chain_q <= chain_d;
`endif
      end
   end

endmodule

// File: tb/tb_cbc_ctl_in.sv
// Bench for cbc_ctl_in: a FIFO model feeds framed words, a word-stream model
// predicts each AES block into a scoreboard ring, and a stub AES core answers
// each start with a done 10 cycles later carrying a known chain value.
module tb_cbc_ctl_in;

   localparam int MAXW = 12;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         i_empty_fifo = 1'b1;
   logic [33:0]  i_data_in = '0;
   logic         o_rd_in;
   logic [127:0] i_iv = '0;
   logic [127:0] i_chain = '0;
   logic         i_aes_done = 1'b0;
   logic         o_aes_start;
   logic [127:0] o_aes_data;
   logic [7:0]   o_data_len;
   logic         o_busy;
   logic         o_err;

   cbc_ctl_in #(.MAX_WORDS(MAXW)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_empty_fifo (i_empty_fifo),
      .i_data_in    (i_data_in),
      .o_rd_in      (o_rd_in),
      .i_iv         (i_iv),
      .i_chain      (i_chain),
      .i_aes_done   (i_aes_done),
      .o_aes_start  (o_aes_start),
      .o_aes_data   (o_aes_data),
      .o_data_len   (o_data_len),
      .o_busy       (o_busy),
      .o_err        (o_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // input FIFO contents (written by stimulus, read pointer owned by driver)
   logic [33:0]  fifo_mem [256];
   logic [127:0] iv_mem   [256];
   int           wr_ptr = 0;
   int           rd_ptr = 0;

   // scoreboard ring of expected blocks
   logic [127:0] sb_data [64];
   logic         sb_last [64];
   int           sb_len  [64];
   int           sb_wr = 0;
   int           sb_rd = 0;

   // what the DUT presented at each start pulse
   logic [127:0] cap_data [64];
   int           cap_len  [64];

   int  start_seen = 0;
   int  err_seen = 0;
   int  viol_seen = 0;
   int  aes_cd = 0;
   int  done_k = 0;
   bit  pop_pend = 1'b0;

   function automatic logic [127:0] chainf(int k);
      logic [31:0] u;
      u = k[31:0];
      return {32'hC4A1_0000 ^ u, 32'h5A5A_0000 + u, ~u, u ^ 32'h1234_5678};
   endfunction

   function automatic logic [127:0] ivf(int n);
      logic [31:0] u;
      u = n[31:0];
      return {32'h1111_0000 + u, 32'hDEAD_0000 ^ u, 32'h0F0F_0F0F + u, ~(u ^ 32'h00FF_00FF)};
   endfunction

   // FIFO model, AES stub and output capture, all sampled on the falling edge.
   always @(negedge clk) begin
      if (pop_pend) rd_ptr = rd_ptr + 1;
      if (rd_ptr < wr_ptr) begin
         i_empty_fifo = 1'b0;
         i_data_in    = fifo_mem[rd_ptr];
         i_iv         = iv_mem[rd_ptr];
      end else begin
         i_empty_fifo = 1'b1;
         i_data_in    = '0;
      end
      if (i_aes_done) i_aes_done = 1'b0;
      if (o_err) err_seen = err_seen + 1;
      if (o_aes_start) begin
         if (start_seen < 64) begin
            cap_data[start_seen] = o_aes_data;
            cap_len[start_seen]  = int'(o_data_len);
         end
         start_seen = start_seen + 1;
         aes_cd = 10;
      end else if (aes_cd > 0) begin
         aes_cd = aes_cd - 1;
         if (aes_cd == 0) begin
            i_aes_done = 1'b1;
            i_chain    = chainf(done_k);
            done_k     = done_k + 1;
         end
      end
      #1;
      pop_pend = o_rd_in;
      if (o_rd_in && (aes_cd > 0 || i_aes_done)) viol_seen = viol_seen + 1;
   end

   // word-stream reference model
   bit           m_in = 1'b0;
   int           m_idx = 0;
   int           m_cnt = 0;
   int           m_blk = 0;
   logic [31:0]  m_lane [4];
   logic [127:0] m_chain = '0;

   task automatic model_word(input logic [1:0] f, input logic [31:0] p, input logic [127:0] iv);
      logic [127:0] blk;
      if (f == 2'b01) begin
         m_in = 1'b1; m_idx = 1; m_cnt = 1; m_lane[0] = p; m_chain = iv;
      end else if (m_in) begin
         if (m_cnt < MAXW) m_cnt = m_cnt + 1;
         m_lane[m_idx] = p;
         if (f == 2'b10 || m_idx == 3) begin
            for (int j = m_idx + 1; j < 4; j++) m_lane[j] = '0;
            blk = {m_lane[3], m_lane[2], m_lane[1], m_lane[0]};
`ifdef CBC_CHAIN_EN
            blk = blk ^ m_chain;
`endif
            sb_data[sb_wr] = blk;
            sb_last[sb_wr] = (f == 2'b10);
            sb_len[sb_wr]  = ((m_cnt + 3) / 4) * 4;
            sb_wr = sb_wr + 1;
            m_chain = chainf(m_blk);
            m_blk = m_blk + 1;
            if (f == 2'b10) m_in = 1'b0;
            else m_idx = 0;
         end else begin
            m_idx = m_idx + 1;
         end
      end
   endtask

   task automatic push_word(input logic [1:0] f, input logic [31:0] p);
      logic [127:0] iv;
      iv = ivf(wr_ptr);
      fifo_mem[wr_ptr] = {f, p};
      iv_mem[wr_ptr]   = iv;
      model_word(f, p, iv);
      wr_ptr = wr_ptr + 1;
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      checks = checks + 1;
      if (act !== exp) begin
         failures = failures + 1;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_vec(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         failures = failures + 1;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic wait_idle(input string tag);
      int  n;
      bit  ok;
      n = 0;
      ok = 1'b0;
      while (!ok && n < 2000) begin
         @(negedge clk); #2;
         n = n + 1;
         if (rd_ptr == wr_ptr && !o_busy && aes_cd == 0 && !i_aes_done) ok = 1'b1;
      end
      checks = checks + 1;
      if (!ok) begin
         failures = failures + 1;
         $display("FAIL %s_timeout: got busy after %0d cycles expected idle", tag, n);
      end
      repeat (3) @(negedge clk);
      #2;
   endtask

   typedef struct {
      int          n;
      logic [31:0] flags;   // word i flag at bits [31-2i -: 2]
      int          starts;
      int          errs;
      int          len;     // -1: no message completes
   } scen_t;

   task automatic run_scen(input scen_t s, input string tag);
      int bs, be, bv;
      bs = start_seen; be = err_seen; bv = viol_seen;
      for (int i = 0; i < s.n; i++) push_word(s.flags[31 - 2*i -: 2], $urandom);
      wait_idle(tag);
      for (int k = bs; k < start_seen && k < 64; k++) begin
         if (sb_rd == sb_wr) begin
            check_int({tag, "_unexpected_block"}, k, -1);
         end else begin
            check_vec({tag, "_blk_data"}, cap_data[k], sb_data[sb_rd]);
            if (sb_last[sb_rd]) check_int({tag, "_blk_len"}, cap_len[k], sb_len[sb_rd]);
            sb_rd = sb_rd + 1;
         end
      end
      check_int({tag, "_sb_left"}, sb_wr - sb_rd, 0);
      check_int({tag, "_starts"}, start_seen - bs, s.starts);
      check_int({tag, "_errs"}, err_seen - be, s.errs);
      check_int({tag, "_pop_in_wait"}, viol_seen - bv, 0);
      if (s.len >= 0) check_int({tag, "_data_len"}, int'(o_data_len), s.len);
      check_int({tag, "_busy"}, int'(o_busy), 0);
   endtask

   task automatic check_all_zero(input string tag);
      check_int({tag, "_rd_in"}, int'(o_rd_in), 0);
      check_int({tag, "_start"}, int'(o_aes_start), 0);
      check_vec({tag, "_aes_data"}, o_aes_data, '0);
      check_int({tag, "_data_len"}, int'(o_data_len), 0);
      check_int({tag, "_busy"}, int'(o_busy), 0);
      check_int({tag, "_err"}, int'(o_err), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      scen_t tbl [8];
      scen_t junk, single;
      int bs, be;

      tbl[0] = '{4,  {2'b01, 2'b00, 2'b00, 2'b10, 24'h0},                 1, 0, 4};
      tbl[1] = '{12, {2'b01, {10{2'b00}}, 2'b10, 8'h0},                   3, 0, 12};
      tbl[2] = '{3,  {2'b01, 2'b00, 2'b10, 26'h0},                        1, 1, 4};
      tbl[3] = '{6,  {2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 2'b10, 20'h0},   1, 1, 4};
      tbl[4] = '{3,  {2'b00, 2'b11, 2'b10, 26'h0},                        0, 3, -1};
      tbl[5] = '{4,  {2'b01, 2'b11, 2'b00, 2'b10, 24'h0},                 1, 1, 4};
      tbl[6] = '{16, {2'b01, {14{2'b00}}, 2'b10},                         4, 4, 12};
      tbl[7] = '{5,  {2'b01, 2'b00, 2'b00, 2'b00, 2'b10, 22'h0},          2, 1, 8};
      junk   = '{3,  {2'b00, 2'b00, 2'b10, 26'h0},                        0, 3, -1};
      single = tbl[0];

      repeat (2) @(negedge clk);
      #1;
      check_all_zero("reset");
      #1 rst_n = 1'b1;
      repeat (2) @(negedge clk);
      #2;

      for (int t = 0; t < 8; t++) run_scen(tbl[t], $sformatf("scen%0d", t));

      // stall in FILL, then reset mid-block
      bs = start_seen;
      push_word(2'b01, 32'hAAAA_0000);
      push_word(2'b00, 32'hAAAA_0001);
      repeat (10) @(negedge clk);
      #2;
      check_int("stall_busy", int'(o_busy), 1);
      check_int("stall_rd_in", int'(o_rd_in), 0);
      check_int("stall_starts", start_seen - bs, 0);
      rst_n = 1'b0;
      #1;
      check_all_zero("midreset");
      m_in = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b1;
      repeat (10) @(negedge clk);
      #2;
      check_int("postreset_starts", start_seen - bs, 0);
      check_int("postreset_busy", int'(o_busy), 0);

      // no block may launch until a fresh 01 word, then normal operation resumes
      run_scen(junk, "postreset_junk");
      be = err_seen;
      run_scen(single, "postreset_msg");
      check_int("postreset_msg_no_err", err_seen - be, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cbc_ctl_in.md
Name: cbc_ctl_in

Overview:
Input-side controller of the AES CBC datapath, sitting between the input FIFO and the AES core.
- Pops 34-bit framed words (2-bit flag + 32-bit payload) from a first-word-fall-through FIFO.
- Packs four words into a 128-bit block and XORs it with the IV (first block) or the previous ciphertext (later blocks).
- Launches the AES core and waits for i_aes_done before packing the next block.
- Supplies the message word count consumed by the output controller.

Parameters:
- MAX_WORDS, 252, saturation limit of the word counter; must be a multiple of 4 and ≤ 252.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst_n  input  1  reset.
- i_empty_fifo  input  1  input FIFO empty.
- i_data_in  input  34  FWFT FIFO head word. [33:32] = flag: 01 first, 00 middle, 10 last, 11 reserved.
- o_rd_in  output  1  FIFO pop; head word is consumed in any cycle where it is high.
- i_iv  input  128  initialisation vector; sampled on the first word of each message.
- i_chain  input  128  AES core output; sampled when i_aes_done is high.
- i_aes_done  input  1  AES block finished (1-cycle pulse).
- o_aes_start  output  1  1-cycle start pulse to the AES core.
- o_aes_data  output  128  block presented to the AES core; held stable from start until done.
- o_data_len  output  8  total words in the current message.
- o_busy  output  1  high whenever state ≠ IDLE.
- o_err  output  1  1-cycle framing-error pulse.

Behaviour:
- Reset: rst_n is asynchronous, active-low. All outputs go to 0, the FSM goes to IDLE, and the word index, chain register and counter are cleared.
  - Reset mid-block drops the partial block.
  - No start pulse is issued after rst_n is released until a new 01-flagged word arrives.
- FSM states: IDLE, FILL, START, WAIT.
- IDLE:
  - o_rd_in = !i_empty_fifo.
  - A popped word flagged 01 → payload goes to block[31:0], i_iv is latched into chain_reg, word counter = 1, idx = 1, go to FILL.
  - A popped word with any other flag is discarded and o_err pulses.
- FILL:
  - o_rd_in = !i_empty_fifo. An empty FIFO stalls the FSM with no timeout.
  - Word idx goes to block[32*idx+31:32*idx]; counter increments.
  - A word with flag 10 sets last_flag.
  - FILL exits after the word at idx 3, or on a 10-flagged word at idx < 3. On a short block, the remaining lanes are zero-padded and o_err pulses.
  - Exit action: o_aes_data <= block ^ chain_reg (registered), go to START.
  - A 01 word in FILL aborts the partial message and restarts as IDLE would with that word (idx = 1, IV reloaded); o_err pulses.
- START:
  - o_aes_start = 1 for exactly one cycle, then go to WAIT.
  - Latency: last word of a block popped at cycle N → o_aes_data valid at N+1, o_aes_start high in cycle N+1.
- WAIT:
  - o_rd_in = 0.
  - On i_aes_done: chain_reg <= i_chain. If last_flag → IDLE; else → FILL with idx = 0.
  - i_aes_done outside WAIT is ignored.
- o_data_len:
  - Updated to the counter value, rounded up to a multiple of 4, in the cycle the last word is popped.
  - Holds that value until the next 01 word.
  - The counter saturates at MAX_WORDS. A pop attempted at saturation pulses o_err, and the word is still consumed.
- Simultaneous events:
  - A pop and a done never coincide, because o_rd_in = 0 in WAIT.
  - A flag 11 word is treated as 00 and pulses o_err.

Optional Feature:
- CBC_CHAIN_EN defined: XOR chaining as above.
- Not defined: ECB mode. chain_reg is removed, o_aes_data = block, and i_iv / i_chain are unused, with no other change to timing or to the FSM.

Test Plan:
1. Single block: push {01,A0},{00,A1},{00,A2},{10,A3}, i_iv = V, done 10 cycles after start → o_aes_data = {A3,A2,A1,A0}^V, exactly one start pulse, o_data_len = 4, return to IDLE, o_err never high.
2. Three-block chain: 12 words, i_chain = C1 then C2 on successive dones → block 2 = P2^C1, block 3 = P3^C2, o_data_len = 12, three start pulses, no pop during WAIT.
3. Short last block: {01,W0},{00,W1},{10,W2} → o_aes_data = {32'h0,W2,W1,W0}^IV, o_err pulses once, o_data_len = 4.
4. Resync: {01,X0},{00,X1},{01,Y0},… → X block discarded, o_err pulse, Y block XORed with the freshly sampled IV.
5. Stall and reset: FIFO empties after 2 words → FSM holds in FILL with o_rd_in = 0. rst_n asserted for 1 cycle mid-FILL → all outputs 0 and no start pulse until a new 01 word.
6. With CBC_CHAIN_EN undefined: repeat scenario 2 → o_aes_data equals each raw packed block.
